vga_timing_decoder: RTL
=======================

// Module: vga_timing_decoder
// PURPOSE
//  Sink-side counterpart of our VGA sync generators: consumes hsync/vsync already in the div_clk domain.
//  Recovers pixel_x/pixel_y/active and measures line and frame length.
//  Checks both lengths against the expected mode and reports lock and timing errors.
//  Sits at the monitor-model / loopback-check end of the display path.
// PARAMETERS
//  H_TOTAL 800 : expected div_clk cycles per line
//  H_SYNC 96 / H_BACK 48 / H_ACTIVE 640 : hsync width, back porch, visible pixels (cycles)
//  V_TOTAL 525 : expected lines per frame
//  V_SYNC 2 / V_BACK 33 / V_ACTIVE 480 : vsync width, back porch, visible lines (lines)
//  SYNC_POL 0 : sync assertion level (0 = active-low, 1 = active-high), both syncs
//  LOCK_FRAMES 2 : consecutive good frames needed to assert locked
// PORTS
//  div_clk     in   1  pixel clock, all logic on rising edge
//  rst_n       in   1  asynchronous active-low reset
//  hsync_in    in   1  horizontal sync, synchronous to div_clk
//  vsync_in    in   1  vertical sync, synchronous to div_clk
//  pixel_x     out 11  column in active region, 0 when !active
//  pixel_y     out 11  row in active region, 0 when !active
//  active      out  1  1 while (h,v) is inside the visible window
//  frame_start out  1  one-cycle pulse per vsync assertion edge
//  line_len    out 11  last measured line period (cycles)
//  frame_len   out 11  last measured frame length (lines)
//  locked      out  1  timing matches the mode
//  timing_err  out  1  one-cycle pulse on any mismatch while locked
// BEHAVIOUR
//  Reset: all outputs and internal counters 0; FSM = SEARCH; previous-sync registers = deasserted level.
//  Edge detect: hs_edge = hsync_in asserted && hs_q deasserted (hs_q = hsync_in registered); vs_edge likewise.
//  h_cnt: cleared on hs_edge; else +1, saturating at 2047.
//  On hs_edge: line_len <= h_cnt+1, saturating at 2047.
//  v_cnt: cleared on vs_edge; else +1 on hs_edge, saturating at 2047.
//  On vs_edge: frame_len <= v_cnt+1. Simultaneous hs_edge+vs_edge: both counters cleared, both lengths latched.
//  Outputs registered from counters (1 cycle after counter update):
//   active = h_cnt in [H_SYNC+H_BACK, +H_ACTIVE) && v_cnt in [V_SYNC+V_BACK, +V_ACTIVE)
//   pixel_x = h_cnt-(H_SYNC+H_BACK), pixel_y = v_cnt-(V_SYNC+V_BACK) when active
//   frame_start = registered vs_edge
//  line_ok: line length == H_TOTAL at each hs_edge.
//   Exception: the first hs_edge after reset or after entering SEARCH is not checked.
//  frame_ok: frame length == V_TOTAL at each vs_edge.
//  FSM (good_cnt counts consecutive good frames):
//   SEARCH: locked=0, good_cnt=0; first vs_edge -> ACQUIRE.
//   ACQUIRE: any bad line clears good_cnt.
//    On vs_edge: frame good and no bad line this frame -> good_cnt+1, else good_cnt=0.
//    good_cnt reaching LOCK_FRAMES -> LOCKED; locked=1 the next cycle.
//   LOCKED: bad line, bad frame, or h_cnt/v_cnt saturating -> timing_err pulse, locked=0, SEARCH.
//  timing_err never pulses outside LOCKED.
//  Sync held asserted continuously produces no further edges; counters saturate and never wrap.
//  Reset mid-frame: immediate return to reset state; the next frame is not trusted (SEARCH).
// TESTING
//  T1 nominal 640x480 stream, 4 frames:
//   -> locked rises 1 cycle after the 3rd vs_edge; frame_len=525, line_len=800, timing_err never 1.
//  T2 locked:
//   -> active row 0 pixel_x runs 0..639 contiguously; pixel_y 0..479; active high 640*480 cycles/frame.
//  T3 locked, then one line of 801 cycles:
//   -> line_len=801, single timing_err pulse, locked=0; relock after 2 further good frames.
//  T4 locked, vsync stops:
//   -> error pulse when v_cnt saturates at 2047; locked=0; frame_start silent; no wrap.
//  T5 rst_n low mid-line, released mid-frame:
//   -> all outputs 0 during reset; no lock before 2 complete good frames after release.
//  T6 SYNC_POL=1 with inverted syncs, coincident hs/vs edges:
//   -> identical results to T1; frame_len=525 (not 524/526).

Source files
------------

// File: rtl/vga_timing_decoder.sv
// Recovers raster position from div_clk-domain hsync/vsync, measures line/frame
// length and tracks lock against the expected video mode.
module vga_timing_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int V_ACTIVE    = 480,
  parameter bit SYNC_POL    = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        div_clk,
  input  logic        rst_n,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [10:0] pixel_x,
  output logic [10:0] pixel_y,
  output logic        active,
  output logic        frame_start,
  output logic [10:0] line_len,
  output logic [10:0] frame_len,
  output logic        locked,
  output logic        timing_err
);

  localparam logic [10:0] CNT_MAX = '1;
  localparam logic [10:0] H_LEN   = 11'(H_TOTAL);
  localparam logic [10:0] V_LEN   = 11'(V_TOTAL);
  localparam logic [11:0] H_START = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] H_STOP  = 12'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [11:0] V_START = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] V_STOP  = 12'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [7:0]  LOCK_N  = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t      state, state_d;
  logic        hs_q, vs_q, hs_edge, vs_edge;
  logic [10:0] h_cnt, v_cnt, line_meas, frame_meas;
  logic        first_line, bad_in_frame;
  logic        line_bad, frame_bad, cnt_sat, err_d, active_d;
  logic [7:0]  good_cnt, good_d;

  assign hs_edge    = (hsync_in == SYNC_POL) && (hs_q != SYNC_POL);
  assign vs_edge    = (vsync_in == SYNC_POL) && (vs_q != SYNC_POL);
  assign line_meas  = (h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + 11'd1;
  assign frame_meas = (v_cnt == CNT_MAX) ? CNT_MAX : v_cnt + 11'd1;
  assign line_bad   = hs_edge && !first_line && (line_meas != H_LEN);
  // A coincident hs_edge closes the last line of the ending frame, so it counts here
  assign frame_bad  = (frame_meas != V_LEN) || bad_in_frame || line_bad;
  assign cnt_sat    = (h_cnt == CNT_MAX) || (v_cnt == CNT_MAX);
  assign active_d   = ({1'b0, h_cnt} >= H_START) && ({1'b0, h_cnt} < H_STOP) &&
                      ({1'b0, v_cnt} >= V_START) && ({1'b0, v_cnt} < V_STOP);

  always_comb begin
    state_d = state;
    good_d  = good_cnt;
    err_d   = 1'b0;
    case (state)
      SEARCH: begin
        good_d = '0;
        if (vs_edge) state_d = ACQUIRE;
      end
      ACQUIRE: begin
        if (vs_edge) begin
          if (frame_bad) begin
            good_d = '0;
          end else begin
            good_d = good_cnt + 8'd1;
            if (good_cnt + 8'd1 >= LOCK_N) state_d = LOCKED;
          end
        end else if (line_bad) begin
          good_d = '0;
        end
      end
      LOCKED: begin
        if (line_bad || (vs_edge && frame_meas != V_LEN) || cnt_sat) begin
          err_d   = 1'b1;
          good_d  = '0;
          state_d = SEARCH;
        end
      end
      default: begin
        good_d  = '0;
        state_d = SEARCH;
      end
    endcase
  end

  always_ff @(posedge div_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SEARCH;
      good_cnt     <= '0;
      hs_q         <= ~SYNC_POL;
      vs_q         <= ~SYNC_POL;
      h_cnt        <= '0;
      v_cnt        <= '0;
      line_len     <= '0;
      frame_len    <= '0;
      first_line   <= 1'b1;
      bad_in_frame <= 1'b0;
    end else begin
      state    <= state_d;
      good_cnt <= good_d;
      hs_q     <= hsync_in;
      vs_q     <= vsync_in;

      if (hs_edge)              h_cnt <= '0;
      else if (h_cnt != CNT_MAX) h_cnt <= h_cnt + 11'd1;

      if (vs_edge)                          v_cnt <= '0;
      else if (hs_edge && v_cnt != CNT_MAX) v_cnt <= v_cnt + 11'd1;

      if (hs_edge) line_len  <= line_meas;
      if (vs_edge) frame_len <= frame_meas;

      if (state_d == SEARCH && state != SEARCH) first_line <= 1'b1;
      else if (hs_edge)                         first_line <= 1'b0;

      if (vs_edge)       bad_in_frame <= 1'b0;
      else if (line_bad) bad_in_frame <= 1'b1;
    end
  end

  always_ff @(posedge div_clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      active      <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      timing_err  <= 1'b0;
    end else begin
      active      <= active_d;
      pixel_x     <= active_d ? h_cnt - H_START[10:0] : '0;
      pixel_y     <= active_d ? v_cnt - V_START[10:0] : '0;
      frame_start <= vs_edge;
      locked      <= (state_d == LOCKED);
      timing_err  <= err_d;
    end
  end

endmodule
